retire_store_buffer: RTL and testbench

- Consumer side of the retire-bus store handshake.
- Captures each committed store (retire_store: store_ready, mem_address, retire_rs2_data) from the ROB head into a small FIFO and answers with a one-cycle store_executed pulse so the ROB can retire the store.
- Drains the FIFO to data memory through a valid/ack write port, in order.
- Provides youngest-match store-to-load forwarding on word addresses; each entry is held as a wc_array record.

---
 rtl/retire_store_buffer_pkg.sv | 33 +++
 rtl/retire_store_buffer_if.sv | 45 ++++
 rtl/retire_store_buffer_fwd_match.sv | 40 ++++
 rtl/retire_store_buffer.sv | 128 ++++++++++++
 tb/tb_retire_store_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/retire_store_buffer_pkg.sv
// Shared types for the retire store buffer: retire-bus store payload,
// buffered store record, drain state and an address helper.
package retire_store_buffer_pkg;

  localparam int unsigned RSB_ADDR_W = 32;
  localparam int unsigned RSB_DATA_W = 32;

  // Committed store as presented by the ROB head on the retire bus.
  typedef struct packed {
    logic                  store_ready;
    logic [RSB_ADDR_W-1:0] mem_address;
    logic [RSB_DATA_W-1:0] retire_rs2_data;
  } retire_store;

  // One buffered store.
  typedef struct packed {
    logic                  valid;
    logic [RSB_ADDR_W-1:0] addr;
    logic [RSB_DATA_W-1:0] data;
  } wc_array;

  // Drain state machine.
  typedef enum logic {
    RSB_IDLE  = 1'b0,
    RSB_WRITE = 1'b1
  } rsb_state;

  // Clear the byte offset so the address names a 32-bit word.
  function automatic logic [RSB_ADDR_W-1:0] word_align(input logic [RSB_ADDR_W-1:0] a);
    return a & ~RSB_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/retire_store_buffer_if.sv
// Retire-store buffer bus bundle.
//   retire side : store_ready, mem_address, retire_rs2_data -> store_executed
//   status      : buf_full, buf_empty
//   memory side : mem_wr_en/addr/data -> mem_wr_ack
//   load probe  : ld_lookup_en/addr -> ld_fwd_hit/data
// master = ROB / memory / load-unit side, slave = the buffer.
interface retire_store_buffer_if
  import retire_store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = RSB_ADDR_W,
  parameter int unsigned DATA_W = RSB_DATA_W
);

  logic              store_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] retire_rs2_data;
  logic              store_executed;
  logic              buf_full;
  logic              buf_empty;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic              ld_lookup_en;
  logic [ADDR_W-1:0] ld_lookup_addr;
  logic              ld_fwd_hit;
  logic [DATA_W-1:0] ld_fwd_data;

  modport master (
    output store_ready, mem_address, retire_rs2_data,
    output mem_wr_ack, ld_lookup_en, ld_lookup_addr,
    input  store_executed, buf_full, buf_empty,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  ld_fwd_hit, ld_fwd_data
  );

  modport slave (
    input  store_ready, mem_address, retire_rs2_data,
    input  mem_wr_ack, ld_lookup_en, ld_lookup_addr,
    output store_executed, buf_full, buf_empty,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output ld_fwd_hit, ld_fwd_data
  );

endinterface

// File: rtl/retire_store_buffer_fwd_match.sv
// Youngest-match store-to-load forwarding selector.
//   entries     : buffered stores (addresses already word aligned)
//   wr_ptr      : next write slot; wr_ptr-1 is the youngest store
//   lookup_en   : probe enable
//   lookup_addr : word-aligned load address
//   hit / data  : youngest valid match, zero when none
module rsb_fwd_match
  import retire_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wc_array [DEPTH-1:0]   entries,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic                  lookup_en,
  input  logic [RSB_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [RSB_DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match written is the youngest one.
  // Valid bits alone delimit the live window, so rd_ptr is not needed here.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (lookup_en) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        idx = wr_ptr - PTR_W'(1) - PTR_W'(k);
        if (entries[idx].valid && (entries[idx].addr == lookup_addr)) begin
          hit  = 1'b1;
          data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/retire_store_buffer.sv
// Retire store buffer: accepts committed stores from the ROB head, pulses
// store_executed, drains them in order to data memory over a valid/ack
// port, and forwards the youngest matching store to load probes.
//   clk, rst_n : clock, async active-low reset
//   bus        : retire_store_buffer_if.slave (retire, memory, load probe)
module retire_store_buffer
  import retire_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RSB_ADDR_W,
  parameter int unsigned DATA_W = RSB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  retire_store_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  retire_store              rs_c;
  wc_array [DEPTH-1:0]      entry_q;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  rsb_state                 state;
  logic                     store_executed_q;
  logic                     mem_wr_en_q;
  logic [ADDR_W-1:0]        mem_wr_addr_q;
  logic [DATA_W-1:0]        mem_wr_data_q;
  logic                     capture_c;
  logic                     ack_c;
  logic [RSB_ADDR_W-1:0]    ld_word_c;
  logic                     fwd_hit_c;
  logic [RSB_DATA_W-1:0]    fwd_data_c;

  assign rs_c = '{store_ready:     bus.store_ready,
                  mem_address:     RSB_ADDR_W'(bus.mem_address),
                  retire_rs2_data: RSB_DATA_W'(bus.retire_rs2_data)};

  // The pulse-cycle guard keeps a still-held store_ready from being taken twice.
  // A slot freed by this cycle's ack is only usable next cycle (count is pre-ack).
  assign capture_c = rs_c.store_ready && (count < CNT_W'(DEPTH)) && !store_executed_q;
  assign ack_c     = (state == RSB_WRITE) && bus.mem_wr_ack;

  // Storage, pointers and occupancy; entries keep word-aligned addresses
  // since both draining and forwarding work on words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      store_executed_q <= 1'b0;
    end else begin
      store_executed_q <= capture_c;
      if (ack_c) begin
        entry_q[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + PTR_W'(1);
      end
      if (capture_c) begin
        entry_q[wr_ptr] <= '{valid: 1'b1,
                             addr:  word_align(rs_c.mem_address),
                             data:  rs_c.retire_rs2_data};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({capture_c, ack_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: present the oldest entry and hold it stable until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RSB_IDLE;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      case (state)
        RSB_IDLE: begin
          if (count != '0) begin
            mem_wr_addr_q <= ADDR_W'(entry_q[rd_ptr].addr);
            mem_wr_data_q <= DATA_W'(entry_q[rd_ptr].data);
            mem_wr_en_q   <= 1'b1;
            state         <= RSB_WRITE;
          end
        end
        RSB_WRITE: begin
          if (bus.mem_wr_ack) begin
            mem_wr_en_q <= 1'b0;
            state       <= RSB_IDLE;
          end
        end
        default: begin
          mem_wr_en_q <= 1'b0;
          state       <= RSB_IDLE;
        end
      endcase
    end
  end

  assign ld_word_c = word_align(RSB_ADDR_W'(bus.ld_lookup_addr));

  rsb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .entries     (entry_q),
    .wr_ptr      (wr_ptr),
    .lookup_en   (bus.ld_lookup_en),
    .lookup_addr (ld_word_c),
    .hit         (fwd_hit_c),
    .data        (fwd_data_c)
  );

  assign bus.store_executed = store_executed_q;
  assign bus.buf_full       = (count == CNT_W'(DEPTH));
  assign bus.buf_empty      = (count == '0);
  assign bus.mem_wr_en      = mem_wr_en_q;
  assign bus.mem_wr_addr    = mem_wr_addr_q;
  assign bus.mem_wr_data    = mem_wr_data_q;
  assign bus.ld_fwd_hit     = fwd_hit_c;
  assign bus.ld_fwd_data    = DATA_W'(fwd_data_c);

endmodule

// File: tb/tb_retire_store_buffer.sv
// Self-checking bench for retire_store_buffer: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_retire_store_buffer;
  import retire_store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  // Behavioural model: in-order queue of committed stores, the head being
  // the one on the write port when m_en is set.
  st_t  mq[$];
  bit   m_pulse;
  bit   m_en;
  st_t  m_pres;
  st_t  drained[$];

  retire_store_buffer_if bus ();

  retire_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    mq.delete();
    m_pulse = 1'b0;
    m_en    = 1'b0;
    m_pres  = '0;
  endfunction

  // Advance the model across one rising edge using the driven inputs.
  function automatic void model_update();
    bit cap;
    cap = bus.store_ready && (mq.size() < DEPTH) && !m_pulse;
    if (m_en) begin
      if (bus.mem_wr_ack) begin
        void'(mq.pop_front());
        m_en = 1'b0;
      end
    end else if (mq.size() > 0) begin
      m_en   = 1'b1;
      m_pres = mq[0];
    end
    if (cap) mq.push_back('{addr: bus.mem_address, data: bus.retire_rs2_data});
    m_pulse = cap;
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ROB behaviour: hold store_ready until store_executed is seen.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, output bit ok);
    bus.store_ready     = 1'b1;
    bus.mem_address     = a;
    bus.retire_rs2_data = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.store_executed === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.store_ready = 1'b0;
  endtask

  // Ack everything; record each write seen on the port, in order.
  task automatic drain_all(output bit ok);
    drained.delete();
    ok = 1'b0;
    bus.mem_wr_ack = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.buf_empty === 1'b1 && bus.mem_wr_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (bus.mem_wr_en === 1'b1) drained.push_back('{addr: bus.mem_wr_addr, data: bus.mem_wr_data});
      tick();
    end
    bus.mem_wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (bus.store_executed !== 1'b0) begin miscompares++; $display("FAIL rst_pulse got %b want 0", bus.store_executed); end
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en got %b want 0", bus.mem_wr_en); end
    vectors++; if (bus.mem_wr_addr !== 32'h0) begin miscompares++; $display("FAIL rst_wr_addr got %h want 0", bus.mem_wr_addr); end
    vectors++; if (bus.mem_wr_data !== 32'h0) begin miscompares++; $display("FAIL rst_wr_data got %h want 0", bus.mem_wr_data); end
    vectors++; if (bus.buf_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", bus.buf_empty); end
    vectors++; if (bus.buf_full !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b want 0", bus.buf_full); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_idle_wr_en got %b want 0", bus.mem_wr_en); end
  endtask

  task automatic test_single_store();
    bit ok;
    push_store(32'h100, 32'hDEAD_BEEF, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_pulse got no pulse want pulse"); end
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_en_early got %b want 0", bus.mem_wr_en); end
    tick();
    vectors++; if (bus.store_executed !== 1'b0) begin miscompares++; $display("FAIL single_pulse_len got %b want 0", bus.store_executed); end
    vectors++; if (bus.mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_en got %b want 1", bus.mem_wr_en); end
    vectors++; if (bus.mem_wr_addr !== 32'h100) begin miscompares++; $display("FAIL single_addr got %h want 100", bus.mem_wr_addr); end
    vectors++; if (bus.mem_wr_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data got %h want deadbeef", bus.mem_wr_data); end
    tick();
    vectors++; if (bus.mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_hold got %b want 1", bus.mem_wr_en); end
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_en_off got %b want 0", bus.mem_wr_en); end
    vectors++; if (bus.buf_empty !== 1'b1) begin miscompares++; $display("FAIL single_empty got %b want 1", bus.buf_empty); end
  endtask

  task automatic test_held_ready();
    bit ok;
    bus.store_ready     = 1'b1;
    bus.mem_address     = 32'h300;
    bus.retire_rs2_data = 32'h1234_5678;
    tick();
    vectors++; if (bus.store_executed !== 1'b1) begin miscompares++; $display("FAIL held_pulse got %b want 1", bus.store_executed); end
    tick();  // store_ready still high during the pulse cycle
    vectors++; if (bus.store_executed !== 1'b0) begin miscompares++; $display("FAIL held_second_pulse got %b want 0", bus.store_executed); end
    bus.store_ready = 1'b0;
    drain_all(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL held_drain_timeout got timeout want empty"); end
    vectors++; if (drained.size() !== 1) begin miscompares++; $display("FAIL held_count got %0d want 1", drained.size()); end
  endtask

  task automatic test_fill();
    bit ok;
    bit seen;
    logic [31:0] exp_a;
    bus.mem_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_store(32'(i * 4), 32'hA000_0000 + 32'(i), ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL fill_pulse%0d got none want pulse", i); end
    end
    bus.store_ready     = 1'b1;
    bus.mem_address     = 32'h10;
    bus.retire_rs2_data = 32'hA000_0004;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.store_executed === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL fill_fifth_pulse got pulse want none"); end
    vectors++; if (bus.buf_full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", bus.buf_full); end
    vectors++; if (bus.mem_wr_addr !== 32'h0) begin miscompares++; $display("FAIL fill_head got %h want 0", bus.mem_wr_addr); end
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    vectors++; if (bus.store_executed !== 1'b0) begin miscompares++; $display("FAIL fill_same_cycle got %b want 0", bus.store_executed); end
    vectors++; if (bus.buf_full !== 1'b0) begin miscompares++; $display("FAIL fill_freed got %b want 0", bus.buf_full); end
    tick();
    vectors++; if (bus.store_executed !== 1'b1) begin miscompares++; $display("FAIL fill_late_pulse got %b want 1", bus.store_executed); end
    vectors++; if (bus.buf_full !== 1'b1) begin miscompares++; $display("FAIL fill_refull got %b want 1", bus.buf_full); end
    bus.store_ready = 1'b0;
    drain_all(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL fill_drain_timeout got timeout want empty"); end
    vectors++; if (drained.size() !== 4) begin miscompares++; $display("FAIL fill_drain_count got %0d want 4", drained.size()); end
    for (int i = 0; i < drained.size() && i < 4; i++) begin
      exp_a = 32'((i + 1) * 4);
      vectors++; if (drained[i].addr !== exp_a) begin miscompares++; $display("FAIL fill_order%0d got %h want %h", i, drained[i].addr, exp_a); end
    end
  endtask

  task automatic test_forwarding();
    bit ok;
    logic [31:0] la [4];
    logic        le [4];
    logic        eh [4];
    logic [31:0] ed [4];
    la = '{32'h202, 32'h208, 32'h205, 32'h200};
    le = '{1'b1, 1'b1, 1'b1, 1'b0};
    eh = '{1'b1, 1'b0, 1'b1, 1'b0};
    ed = '{32'h33, 32'h0, 32'h22, 32'h0};
    bus.mem_wr_ack = 1'b0;
    push_store(32'h200, 32'h11, ok);
    push_store(32'h204, 32'h22, ok);
    push_store(32'h200, 32'h33, ok);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.ld_lookup_en   = le[i];
      bus.ld_lookup_addr = la[i];
      #1;
      vectors++; if (bus.ld_fwd_hit !== eh[i]) begin miscompares++; $display("FAIL fwd_hit%0d got %b want %b", i, bus.ld_fwd_hit, eh[i]); end
      vectors++; if (bus.ld_fwd_data !== ed[i]) begin miscompares++; $display("FAIL fwd_data%0d got %h want %h", i, bus.ld_fwd_data, ed[i]); end
    end
    bus.ld_lookup_en = 1'b0;
    drain_all(ok);
    vectors++; if (drained.size() !== 3) begin miscompares++; $display("FAIL fwd_drain_count got %0d want 3", drained.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.mem_wr_ack = 1'b0;
    push_store(32'h400, 32'hB0, ok);
    push_store(32'h404, 32'hB1, ok);
    tick();
    vectors++; if (bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== 32'h400) begin miscompares++; $display("FAIL b2b_head got en=%b addr=%h want en=1 addr=400", bus.mem_wr_en, bus.mem_wr_addr); end
    bus.store_ready     = 1'b1;
    bus.mem_address     = 32'h408;
    bus.retire_rs2_data = 32'hB2;
    bus.mem_wr_ack      = 1'b1;
    tick();
    bus.store_ready = 1'b0;
    bus.mem_wr_ack  = 1'b0;
    vectors++; if (bus.store_executed !== 1'b1) begin miscompares++; $display("FAIL b2b_pulse got %b want 1", bus.store_executed); end
    vectors++; if (bus.buf_empty !== 1'b0 || bus.buf_full !== 1'b0) begin miscompares++; $display("FAIL b2b_status got empty=%b full=%b want 0 0", bus.buf_empty, bus.buf_full); end
    drain_all(ok);
    vectors++; if (drained.size() !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", drained.size()); end
    if (drained.size() == 2) begin
      vectors++; if (drained[0].addr !== 32'h404 || drained[0].data !== 32'hB1) begin miscompares++; $display("FAIL b2b_first got %h/%h want 404/b1", drained[0].addr, drained[0].data); end
      vectors++; if (drained[1].addr !== 32'h408 || drained[1].data !== 32'hB2) begin miscompares++; $display("FAIL b2b_second got %h/%h want 408/b2", drained[1].addr, drained[1].data); end
    end
  endtask

  task automatic test_random();
    bit          exp_hit;
    logic [31:0] exp_data;
    for (int cyc = 0; cyc < 400; cyc++) begin
      vectors++; if (bus.store_executed !== m_pulse) begin miscompares++; $display("FAIL rnd_pulse cyc=%0d got %b want %b", cyc, bus.store_executed, m_pulse); end
      vectors++; if (bus.mem_wr_en !== m_en) begin miscompares++; $display("FAIL rnd_wr_en cyc=%0d got %b want %b", cyc, bus.mem_wr_en, m_en); end
      vectors++; if (bus.buf_full !== (mq.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full cyc=%0d got %b want %b", cyc, bus.buf_full, mq.size() == DEPTH); end
      vectors++; if (bus.buf_empty !== (mq.size() == 0)) begin miscompares++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, bus.buf_empty, mq.size() == 0); end
      if (m_en) begin
        vectors++; if (bus.mem_wr_addr !== (m_pres.addr & 32'hFFFF_FFFC)) begin miscompares++; $display("FAIL rnd_addr cyc=%0d got %h want %h", cyc, bus.mem_wr_addr, m_pres.addr & 32'hFFFF_FFFC); end
        vectors++; if (bus.mem_wr_data !== m_pres.data) begin miscompares++; $display("FAIL rnd_data cyc=%0d got %h want %h", cyc, bus.mem_wr_data, m_pres.data); end
      end
      if (bus.store_ready && bus.store_executed === 1'b1) bus.store_ready = 1'b0;
      if (!bus.store_ready && $urandom_range(0, 2) != 0) begin
        bus.store_ready     = 1'b1;
        bus.mem_address     = 32'h500 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
        bus.retire_rs2_data = $urandom;
      end
      bus.mem_wr_ack     = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      bus.ld_lookup_en   = ($urandom_range(0, 3) != 0);
      bus.ld_lookup_addr = 32'h500 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      #1;
      exp_hit  = 1'b0;
      exp_data = 32'h0;
      if (bus.ld_lookup_en) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].addr[31:2] == bus.ld_lookup_addr[31:2]) begin
            exp_hit  = 1'b1;
            exp_data = mq[i].data;
            break;
          end
        end
      end
      vectors++; if (bus.ld_fwd_hit !== exp_hit) begin miscompares++; $display("FAIL rnd_fwd_hit cyc=%0d got %b want %b", cyc, bus.ld_fwd_hit, exp_hit); end
      vectors++; if (bus.ld_fwd_data !== exp_data) begin miscompares++; $display("FAIL rnd_fwd_data cyc=%0d got %h want %h", cyc, bus.ld_fwd_data, exp_data); end
      tick();
    end
    bus.store_ready  = 1'b0;
    bus.mem_wr_ack   = 1'b0;
    bus.ld_lookup_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bus.mem_wr_ack = 1'b0;
    push_store(32'h600, 32'hCAFE_0001, ok);
    tick();
    vectors++; if (bus.mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_pre_en got %b want 1", bus.mem_wr_en); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_en got %b want 0", bus.mem_wr_en); end
    vectors++; if (bus.buf_empty !== 1'b1) begin miscompares++; $display("FAIL mid_empty got %b want 1", bus.buf_empty); end
    vectors++; if (bus.store_executed !== 1'b0) begin miscompares++; $display("FAIL mid_pulse got %b want 0", bus.store_executed); end
    vectors++; if (bus.mem_wr_addr !== 32'h0) begin miscompares++; $display("FAIL mid_addr got %h want 0", bus.mem_wr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    tick();
    vectors++; if (bus.mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_lost got %b want 0", bus.mem_wr_en); end
  endtask

  initial begin
    vectors             = 0;
    miscompares         = 0;
    rst_n               = 1'b1;
    bus.store_ready     = 1'b0;
    bus.mem_address     = '0;
    bus.retire_rs2_data = '0;
    bus.mem_wr_ack      = 1'b0;
    bus.ld_lookup_en    = 1'b0;
    bus.ld_lookup_addr  = '0;
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_single_store();
    test_held_ready();
    test_fill();
    test_forwarding();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
